// File: rtl/router_pkg.sv
// Shared types for the parametrised router control FSM: state encoding and address checks.
package router_pkg;

  typedef enum logic [3:0] {
    StDa   = 4'd0,
    StLfd  = 4'd1,
    StLd   = 4'd2,
    StLp   = 4'd3,
    StFfs  = 4'd4,
    StLaf  = 4'd5,
    StWte  = 4'd6,
    StCpe  = 4'd7,
    StDrop = 4'd8
  } state_e;

  function automatic logic is_valid_addr(input int unsigned addr, input int unsigned num_ch);
    return addr < num_ch;
  endfunction

endpackage

// File: rtl/router_fsm_nch.sv
// Router control FSM for NUM_CH output FIFOs: header/payload/parity sequencing, drop and wait.
// Optional wait timeout is enabled by defining ROUTER_FSM_WAIT_TIMEOUT_EN.
module router_fsm_nch
  import router_pkg::*;
#(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned ADDR_W      = 2,
  parameter int unsigned WAIT_CYCLES = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic [NUM_CH-1:0] soft_reset,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic [ADDR_W-1:0] addr_q,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg,
  output logic              busy,
  output logic              drop_state,
  output logic              wait_timeout
);

  state_e state_q, state_d;
  logic   valid_addr;
  logic   empty_in;
  logic   empty_sel;
  logic   srst_sel;
  logic   timeout_hit;

  assign valid_addr = is_valid_addr(32'(data_in), NUM_CH);

  // Compare-based lookup keeps out-of-range addresses at 0 instead of indexing past the vector.
  always_comb begin
    empty_in  = 1'b0;
    empty_sel = 1'b0;
    srst_sel  = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (data_in == ADDR_W'(i)) begin
        empty_in = fifo_empty[i];
      end
      if (addr_q == ADDR_W'(i)) begin
        empty_sel = fifo_empty[i];
        srst_sel  = soft_reset[i];
      end
    end
  end

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  localparam int unsigned TimerW = $clog2(WAIT_CYCLES + 1);

  logic [TimerW-1:0] timer_q, timer_d;
  logic              wait_timeout_q;

  assign timeout_hit = (state_q == StWte) && (timer_q == TimerW'(WAIT_CYCLES - 1)) && !empty_sel;
  // Held at zero outside WTE, so every entry starts counting from zero.
  assign timer_d     = (state_q == StWte) ? timer_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q        <= '0;
      wait_timeout_q <= 1'b0;
    end else begin
      timer_q        <= timer_d;
      wait_timeout_q <= (state_q == StWte) && (state_d == StDrop);
    end
  end

  assign wait_timeout = wait_timeout_q;
`else
  logic unused_wait_cycles;

  assign timeout_hit        = 1'b0;
  assign wait_timeout       = 1'b0;
  assign unused_wait_cycles = ^WAIT_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StDa: begin
        if (pkt_valid) begin
          if (!valid_addr) begin
            state_d = StDrop;
          end else if (empty_in) begin
            state_d = StLfd;
          end else begin
            state_d = StWte;
          end
        end
      end
      StLfd: state_d = StLd;
      StLd: begin
        if (fifo_full) begin
          state_d = StFfs;
        end else if (!pkt_valid) begin
          state_d = StLp;
        end
      end
      StLp:  state_d = StCpe;
      StCpe: state_d = fifo_full ? StFfs : StDa;
      StFfs: state_d = fifo_full ? StFfs : StLaf;
      StLaf: begin
        if (parity_done) begin
          state_d = StDa;
        end else if (low_pkt_valid) begin
          state_d = StLp;
        end else begin
          state_d = StLd;
        end
      end
      StWte: begin
        if (empty_sel) begin
          state_d = StLfd;
        end else if (timeout_hit) begin
          state_d = StDrop;
        end
      end
      StDrop: state_d = pkt_valid ? StDrop : StDa;
      default: state_d = StDa;
    endcase
    // Only the channel in use may abort the packet.
    if (state_q != StDa && srst_sel) begin
      state_d = StDa;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StDa;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StDa && pkt_valid) begin
        addr_q <= data_in;
      end
    end
  end

  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    busy          = 1'b0;
    drop_state    = 1'b0;
    unique case (state_q)
      StDa:  detect_add = 1'b1;
      StLfd: begin
        lfd_state = 1'b1;
        busy      = 1'b1;
      end
      StLd: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
      end
      StLp: begin
        write_enb_reg = 1'b1;
        busy          = 1'b1;
      end
      StCpe: begin
        rst_int_reg = 1'b1;
        busy        = 1'b1;
      end
      StFfs: begin
        full_state = 1'b1;
        busy       = 1'b1;
      end
      StLaf: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b1;
      end
      StWte:  busy = 1'b1;
      StDrop: drop_state = 1'b1;
      default: detect_add = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_router_fsm_nch.sv
// Self-checking bench for router_fsm_nch: directed vector table, corner sequences, random vs model.
module tb_router_fsm_nch;

  localparam int unsigned NumCh      = 3;
  localparam int unsigned AddrW      = 2;
  localparam int unsigned WaitCycles = 4;

  logic             clk;
  logic             rst;
  logic             pkt_valid;
  logic [AddrW-1:0] data_in;
  logic             fifo_full;
  logic [NumCh-1:0] fifo_empty;
  logic [NumCh-1:0] soft_reset;
  logic             parity_done;
  logic             low_pkt_valid;
  logic [AddrW-1:0] addr_q;
  logic detect_add, lfd_state, ld_state, laf_state, full_state;
  logic write_enb_reg, rst_int_reg, busy, drop_state, wait_timeout;

  router_fsm_nch #(
    .NUM_CH     (NumCh),
    .ADDR_W     (AddrW),
    .WAIT_CYCLES(WaitCycles)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .soft_reset   (soft_reset),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .addr_q       (addr_q),
    .detect_add   (detect_add),
    .lfd_state    (lfd_state),
    .ld_state     (ld_state),
    .laf_state    (laf_state),
    .full_state   (full_state),
    .write_enb_reg(write_enb_reg),
    .rst_int_reg  (rst_int_reg),
    .busy         (busy),
    .drop_state   (drop_state),
    .wait_timeout (wait_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {M_DA, M_LFD, M_LD, M_LP, M_CPE, M_FFS, M_LAF, M_WTE, M_DROP} mode_e;

  typedef struct {
    logic       pv;
    logic [1:0] din;
    logic       ff;
    logic [2:0] fe;
    logic [2:0] sr;
    logic       pd;
    logic       lpv;
    mode_e      exp_mode;
    logic [1:0] exp_addr;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: packet phase, latched channel, cycles spent waiting, timeout pulse.
  mode_e      m_mode;
  logic [1:0] m_addr;
  int         m_waited;
  logic       m_pulse;

  function automatic logic [8:0] flags(input mode_e m);
    logic [8:0] f;
    f    = '0;
    f[8] = (m == M_DA);
    f[7] = (m == M_LFD);
    f[6] = (m == M_LD);
    f[5] = (m == M_LAF);
    f[4] = (m == M_FFS);
    f[3] = (m inside {M_LD, M_LAF, M_LP});
    f[2] = (m == M_CPE);
    f[1] = (m inside {M_LFD, M_LP, M_CPE, M_FFS, M_LAF, M_WTE});
    f[0] = (m == M_DROP);
    return f;
  endfunction

  function automatic logic [8:0] dut_flags();
    return {detect_add, lfd_state, ld_state, laf_state, full_state,
            write_enb_reg, rst_int_reg, busy, drop_state};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode   = M_DA;
    m_addr   = '0;
    m_waited = 0;
    m_pulse  = 1'b0;
  endtask

  task automatic model_step();
    int    a;
    bit    v, e_in, e_sel, sr;
    mode_e nx;
    a     = int'(data_in);
    v     = a < int'(NumCh);
    e_in  = v ? fifo_empty[a] : 1'b0;
    e_sel = (int'(m_addr) < int'(NumCh)) ? fifo_empty[m_addr] : 1'b0;
    sr    = (int'(m_addr) < int'(NumCh)) ? soft_reset[m_addr] : 1'b0;
    nx    = m_mode;
    case (m_mode)
      M_DA:   if (pkt_valid) nx = !v ? M_DROP : (e_in ? M_LFD : M_WTE);
      M_LFD:  nx = M_LD;
      M_LD:   nx = fifo_full ? M_FFS : (!pkt_valid ? M_LP : M_LD);
      M_LP:   nx = M_CPE;
      M_CPE:  nx = fifo_full ? M_FFS : M_DA;
      M_FFS:  nx = fifo_full ? M_FFS : M_LAF;
      M_LAF:  nx = parity_done ? M_DA : (low_pkt_valid ? M_LP : M_LD);
      M_WTE: begin
        if (e_sel) nx = M_LFD;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
        else if (m_waited + 1 >= int'(WaitCycles)) nx = M_DROP;
`endif
        else nx = M_WTE;
      end
      M_DROP: nx = pkt_valid ? M_DROP : M_DA;
      default: nx = M_DA;
    endcase
    if (m_mode != M_DA && sr) nx = M_DA;
    m_pulse  = (m_mode == M_WTE) && (nx == M_DROP);
    m_waited = (m_mode == M_WTE) ? m_waited + 1 : 0;
    if (m_mode == M_DA && pkt_valid) m_addr = data_in;
    m_mode = nx;
  endtask

  task automatic drive(input logic pv, input int din, input logic ff, input int fe,
                       input int sr, input logic pd, input logic lpv);
    pkt_valid     = pv;
    data_in       = AddrW'(din);
    fifo_full     = ff;
    fifo_empty    = NumCh'(fe);
    soft_reset    = NumCh'(sr);
    parity_done   = pd;
    low_pkt_valid = lpv;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " flags"}, 32'(dut_flags()), 32'(flags(m_mode)));
    check({tag, " addr_q"}, 32'(addr_q), 32'(m_addr));
    check({tag, " wait_timeout"}, 32'(wait_timeout), 32'(m_pulse));
  endtask

  function automatic vec_t mk(input logic pv, input int din, input logic ff, input int fe,
                              input int sr, input logic pd, input logic lpv,
                              input mode_e ex, input int ea);
    vec_t r;
    r.pv = pv; r.din = 2'(din); r.ff = ff; r.fe = 3'(fe); r.sr = 3'(sr);
    r.pd = pd; r.lpv = lpv; r.exp_mode = ex; r.exp_addr = 2'(ea);
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    // Normal packet to channel 2
    tbl.push_back(mk(1, 2, 0, 7, 0, 0, 0, M_LFD, 2));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 2, 0, 7, 0, 0, 0, M_LD, 2));
    tbl.push_back(mk(0, 0, 0, 7, 0, 0, 0, M_LP, 2));
    tbl.push_back(mk(0, 0, 0, 7, 0, 0, 0, M_CPE, 2));
    tbl.push_back(mk(0, 0, 0, 7, 0, 0, 0, M_DA, 2));
    // Wait on busy channel 1, then full/almost-full handling
    tbl.push_back(mk(1, 1, 0, 5, 0, 0, 0, M_WTE, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 0, 5, 0, 0, 0, M_WTE, 1));
    tbl.push_back(mk(1, 1, 0, 7, 0, 0, 0, M_LFD, 1));
    tbl.push_back(mk(1, 1, 0, 7, 0, 0, 0, M_LD, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 1, 7, 0, 0, 0, M_FFS, 1));
    tbl.push_back(mk(1, 1, 0, 7, 0, 0, 0, M_LAF, 1));
    tbl.push_back(mk(0, 0, 0, 7, 0, 0, 1, M_LP, 1));
    tbl.push_back(mk(0, 0, 0, 7, 0, 0, 0, M_CPE, 1));
    tbl.push_back(mk(0, 0, 1, 7, 0, 0, 0, M_FFS, 1));
    tbl.push_back(mk(0, 0, 0, 7, 0, 0, 0, M_LAF, 1));
    tbl.push_back(mk(0, 0, 0, 7, 0, 1, 1, M_DA, 1));
    // Out-of-range address dropped; its soft reset index is out of range too
    tbl.push_back(mk(1, 3, 0, 7, 0, 0, 0, M_DROP, 3));
    tbl.push_back(mk(1, 3, 0, 7, 7, 0, 0, M_DROP, 3));
    tbl.push_back(mk(0, 0, 0, 7, 0, 0, 0, M_DA, 3));
    // Soft reset: other channel ignored, own channel aborts, ignored in DA
    tbl.push_back(mk(1, 1, 0, 7, 0, 0, 0, M_LFD, 1));
    tbl.push_back(mk(1, 1, 0, 7, 4, 0, 0, M_LD, 1));
    tbl.push_back(mk(1, 1, 0, 7, 4, 0, 0, M_LD, 1));
    tbl.push_back(mk(1, 1, 0, 7, 2, 0, 0, M_DA, 1));
    tbl.push_back(mk(0, 0, 0, 7, 7, 0, 0, M_DA, 1));
    // Channel 0 packet, only fifo 0 empty
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, M_LFD, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, M_LD, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, M_LP, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, M_CPE, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, M_DA, 0));

    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset flags", 32'(dut_flags()), 32'h100);
    check("reset addr_q", 32'(addr_q), 32'h0);
    check("reset wait_timeout", 32'(wait_timeout), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].pv, int'(tbl[i].din), tbl[i].ff, int'(tbl[i].fe), int'(tbl[i].sr),
            tbl[i].pd, tbl[i].lpv);
      step();
      check($sformatf("vec%0d flags", i), 32'(dut_flags()), 32'(flags(tbl[i].exp_mode)));
      check($sformatf("vec%0d addr_q", i), 32'(addr_q), 32'(tbl[i].exp_addr));
      check($sformatf("vec%0d wait_timeout", i), 32'(wait_timeout), 32'h0);
    end

    // Async reset in the middle of FFS
    drive(1, 0, 0, 7, 0, 0, 0); step();
    drive(1, 0, 0, 7, 0, 0, 0); step();
    drive(1, 0, 1, 7, 0, 0, 0); step();
    check("pre-reset FFS", 32'(dut_flags()), 32'(flags(M_FFS)));
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check("async reset flags", 32'(dut_flags()), 32'h100);
    check("async reset addr_q", 32'(addr_q), 32'h0);
    @(negedge clk);
    drive(0, 0, 0, 7, 0, 0, 0);
    rst = 1'b1;

    // Wait on channel 2 with its FIFO never draining
    drive(1, 2, 0, 0, 0, 0, 0); step();
    check_model("wte entry");
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      step();
      check("wte hold", 32'(dut_flags()), 32'(flags(M_WTE)));
    end
    step();
    check("timeout drop", 32'(dut_flags()), 32'(flags(M_DROP)));
    check("timeout pulse", 32'(wait_timeout), 32'h1);
    step();
    check("timeout pulse end", 32'(wait_timeout), 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0); step();
    check_model("drop exit");
`else
    for (int i = 0; i < 100; i++) begin
      step();
      check("wte hold", 32'(dut_flags()), 32'(flags(M_WTE)));
    end
    check("no timeout", 32'(wait_timeout), 32'h0);
    drive(1, 2, 0, 4, 0, 0, 0); step();
    check_model("wte release");
    drive(0, 0, 0, 4, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_model("drain");
    end
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 9) < 8), int'($urandom_range(0, 3)),
            ($urandom_range(0, 4) == 0), int'($urandom_range(0, 7)),
            ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 7)) : 0,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
      step();
      check_model("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/router_fsm_nch.md
Name: router_fsm_nch

Overview:
Parametrised successor of the router1x3 control FSM. Sequences one input packet stream (header, payload, parity) into one of NUM_CH output FIFOs, generating the load, full-hold and busy controls for the register and synchroniser blocks. New over the 3-channel version:
- waits correctly on any channel;
- discards packets whose address is out of range (DROP state);
- honours soft reset only for the channel currently in use;
- exports the latched channel address;
- optional wait timeout.

Parameters:
NUM_CH, 3, number of output channels/FIFOs (2..16)
ADDR_W, 2, header address field width; must satisfy 2**ADDR_W >= NUM_CH
WAIT_CYCLES, 30, WTE timeout length in clk cycles (used only with ROUTER_FSM_WAIT_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
pkt_valid  in  1  packet in progress on data_in
data_in  in  ADDR_W  header address field (data_in[ADDR_W-1:0] of header byte)
fifo_full  in  1  selected FIFO full
fifo_empty  in  NUM_CH  per-channel FIFO empty
soft_reset  in  NUM_CH  per-channel soft reset from synchroniser
parity_done  in  1  parity byte captured by register block
low_pkt_valid  in  1  pkt_valid fell while in FFS/LAF
addr_q  out  ADDR_W  latched destination channel
detect_add, lfd_state, ld_state, laf_state, full_state  out  1 each  state decodes
write_enb_reg  out  1  FIFO write enable request
rst_int_reg  out  1  internal register reset (check parity)
busy  out  1  stall source
drop_state  out  1  packet being discarded
wait_timeout  out  1  one-cycle pulse, WTE abandoned (0 when feature off)

Behaviour:
- Reset (rst=0, async): state=DA, addr_q=0, timer=0. Outputs: detect_add=1, all others 0.
- States: DA, LFD, LD, LP, CPE, FFS, LAF, WTE, DROP. All outputs are Moore decodes of the registered state; latency is 0 cycles from the state register.
- Address capture: in DA, addr_q<=data_in when pkt_valid=1; otherwise addr_q holds. valid_addr = (data_in < NUM_CH).
- DA:
  - pkt_valid & valid_addr & fifo_empty[data_in] -> LFD
  - pkt_valid & valid_addr & !fifo_empty[data_in] -> WTE
  - pkt_valid & !valid_addr -> DROP
  - else DA
- LFD -> LD.
- LD: fifo_full -> FFS; else !pkt_valid -> LP; else LD.
- LP -> CPE.
- CPE: fifo_full -> FFS; else DA.
- FFS: fifo_full -> FFS; else LAF.
- LAF: parity_done -> DA (highest priority); else low_pkt_valid -> LP; else LD.
- WTE: fifo_empty[addr_q] -> LFD; else WTE.
- DROP: pkt_valid -> DROP; else DA. The parity byte arrives with pkt_valid=0 and is discarded.
- Soft reset: soft_reset[addr_q]=1 in any state except DA forces DA next cycle, overriding the transition above. Soft resets of other channels are ignored. All soft resets are ignored in DA.
- Output decodes:
  - busy=1 in LFD, LP, CPE, FFS, LAF, WTE; busy=0 in DA, LD, DROP (the source keeps streaming so the packet drains).
  - write_enb_reg=1 in LD, LAF, LP.
  - rst_int_reg=1 in CPE.
  - drop_state=1 in DROP.
- Index safety: fifo_empty/soft_reset are indexed only with valid addresses; any out-of-range index evaluates as 0 and never produces X.

Optional Feature:
ROUTER_FSM_WAIT_TIMEOUT_EN:
- Defined:
  - A $clog2(WAIT_CYCLES+1)-bit timer clears on WTE entry and increments each cycle in WTE.
  - If the timer reaches WAIT_CYCLES-1 with fifo_empty[addr_q]=0: next=DROP and wait_timeout pulses 1 cycle. DROP drains the packet.
  - fifo_empty[addr_q]=1 in the same cycle wins -> LFD.
- Undefined: no timer; wait_timeout tied 0; WTE waits indefinitely.

Decomposition:
- Package router_pkg: state enum/localparams (4-bit: DA=0, LFD=1, LD=2, LP=3, FFS=4, LAF=5, WTE=6, CPE=7, DROP=8) and the function is_valid_addr(addr, NUM_CH).
- Single module. The timer lives in-line under the macro; no sub-module.

Test Plan:
- NUM_CH=4: header addr=3, fifo_empty=4'b1111, 5 payload cycles then pkt_valid=0 -> DA,LFD,LD x5,LP,CPE,DA; rst_int_reg=1 for exactly 1 cycle; addr_q=3.
- addr=2 with fifo_empty[2]=0 for 6 cycles, then 1 -> WTE with busy=1 for 6 cycles, then LFD. Repeat for addr=0,1,3.
- NUM_CH=3, header addr=3 -> DROP, busy=0, drop_state=1 until pkt_valid=0, then DA; no write_enb_reg.
- In LD, fifo_full=1 for 3 cycles, then 0 with low_pkt_valid=1 -> FFS x3, LAF, LP, CPE; then parity_done=1 on the next LAF visit -> DA.
- addr_q=1 in LD: soft_reset=3'b100 -> no effect; soft_reset=3'b010 -> DA next cycle. rst asserted mid-FFS -> DA immediately with all outputs at reset values.
- Macro defined, WAIT_CYCLES=4, fifo_empty held 0 in WTE -> DROP after 4 WTE cycles with wait_timeout=1 for exactly 1 cycle. Macro undefined -> remains in WTE for 100 cycles.
